mux_varredura: RTL and testbench
================================

Name: mux_varredura

Overview:
- Parametrised, registered N-channel, W-bit multiplexer.
- Next generation of the team's 4:1 mux built from 2:1 stages.
- Adds manual selection, an automatic round-robin scan mode with a per-channel dwell time, and a channel-enable mask.
- Feeds display and bench multiplexing logic that previously needed an external selector clock.

Parameters:
- CANAIS, 8: number of input channels, >= 2.
- LARGURA, 4: bits per channel, >= 1.
- PERMANENCIA, 4: dwell time in clock cycles per channel in scan mode, >= 1.
- SELW (localparam), clog2(CANAIS) (minimum 1): width of the select and index buses.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- ENTRADAS  in  CANAIS*LARGURA  packed data; channel i occupies bits [i*LARGURA +: LARGURA].
- MASCARA  in  CANAIS  channel enable; bit i = 1 means channel i is selectable.
- HABILITA  in  1  global run enable.
- MODO  in  1  0 = manual selection, 1 = automatic scan.
- SEL  in  SELW  manual channel select.
- SAIDA  out  LARGURA  registered selected data.
- CANAL  out  SELW  index of the channel currently driving SAIDA.
- VALIDO  out  1  SAIDA holds data from an enabled channel.
- FIM_CICLO  out  1  one-cycle pulse when the scan wraps around.

Behaviour:
- Reset (RST_N = 0, takes effect immediately, including mid-operation):
  - SAIDA = 0, CANAL = 0, VALIDO = 0, FIM_CICLO = 0.
  - Dwell counter = 0; state = PARADO.
- States: PARADO, MANUAL, VARRENDO.
- HABILITA = 0 in any state:
  - Next state is PARADO; VALIDO goes to 0 next cycle.
  - SAIDA and CANAL hold; FIM_CICLO = 0.
- PARADO:
  - HABILITA = 1 and MODO = 0 -> MANUAL.
  - HABILITA = 1 and MODO = 1 -> VARRENDO, dwell counter = 0, scanning starts from the current CANAL.
- MANUAL, every cycle:
  - SAIDA <= channel SEL; CANAL <= SEL; VALIDO <= MASCARA[SEL].
  - Latency from SEL/ENTRADAS to SAIDA is 1 cycle.
  - SEL >= CANAIS (non-power-of-2 CANAIS): SAIDA <= 0, VALIDO <= 0, CANAL holds.
  - MODO = 1 -> VARRENDO next cycle; counter = 0; scan starts from the current CANAL.
- VARRENDO, every cycle:
  - SAIDA <= channel CANAL (live data, 1-cycle latency); VALIDO <= MASCARA[CANAL].
  - Counter increments each cycle.
  - When counter = PERMANENCIA-1: counter <= 0, and CANAL <= next index above CANAL with MASCARA = 1, searching modulo CANAIS.
  - Wrap-around (new index <= old index): FIM_CICLO = 1 for exactly that cycle.
  - Current CANAL becomes masked mid-dwell: advance on the next edge regardless of the counter; counter <= 0.
  - Single enabled channel: CANAL stays constant; FIM_CICLO pulses every PERMANENCIA cycles.
  - MASCARA all zero: VALIDO = 0, CANAL holds, counter held at 0, no FIM_CICLO.
  - PERMANENCIA = 1: advance every cycle.
  - MODO = 0 -> MANUAL next cycle; counter cleared.
- Simultaneous HABILITA = 0 and MODO change: HABILITA takes priority (go to PARADO).
- SAIDA is the only data path. It is fully registered, so there is no combinational path from the inputs to any output.

Optional Feature:
- Macro: MUX_VARREDURA_PARIDADE_EN.
- When defined:
  - Adds output port PARIDADE (out, 1) = even parity (XOR reduction) of the data loaded into SAIDA.
  - PARIDADE is registered in the same cycle as SAIDA and resets to 0.
  - Forced to 0 whenever VALIDO would be 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RST_N = 0 with random inputs -> SAIDA = 0, CANAL = 0, VALIDO = 0, FIM_CICLO = 0. Assert RST_N low mid-scan -> outputs clear without waiting for a clock edge.
- Manual mode: CANAIS = 8, LARGURA = 4, channel i = i+3, MASCARA = 8'hFF, HABILITA = 1, MODO = 0, SEL = 5 -> next cycle SAIDA = 8, CANAL = 5, VALIDO = 1. Then MASCARA[5] = 0 -> VALIDO = 0.
- Scan mode: MODO = 1, PERMANENCIA = 4, MASCARA = 8'b1010_0101 -> CANAL sequence 0, 2, 5, 7, 0, each held 4 cycles. FIM_CICLO = 1 only on the 7 -> 0 transition.
- Mask edges:
  - MASCARA = 0 -> VALIDO = 0, CANAL frozen, no FIM_CICLO.
  - MASCARA = 8'h08 -> CANAL = 3 permanently; FIM_CICLO every 4 cycles.
  - Clear the current channel's bit mid-dwell -> advance on the next edge.
- Control priority: in VARRENDO at CANAL = 2, drop HABILITA -> VALIDO = 0, CANAL = 2 held. Raise HABILITA -> scan resumes at 2 with a full 4-cycle dwell.
- Parity (MUX_VARREDURA_PARIDADE_EN defined): select data 4'b0111 -> PARIDADE = 1. Select 4'b0110 -> PARIDADE = 0. Masked channel -> PARIDADE = 0.

Source files
------------

// File: rtl/mux_varredura.sv
// Registered N-channel, W-bit multiplexer with manual select, round-robin scan with per-channel dwell, and enable mask.
// Optional PARIDADE output (even parity of SAIDA) when MUX_VARREDURA_PARIDADE_EN is defined.
module mux_varredura #(
  parameter int CANAIS      = 8,
  parameter int LARGURA     = 4,
  parameter int PERMANENCIA = 4,
  localparam int SELW       = (CANAIS > 2) ? $clog2(CANAIS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [CANAIS*LARGURA-1:0]   ENTRADAS,
  input  logic [CANAIS-1:0]           MASCARA,
  input  logic                        HABILITA,
  input  logic                        MODO,
  input  logic [SELW-1:0]             SEL,
  output logic [LARGURA-1:0]          SAIDA,
  output logic [SELW-1:0]             CANAL,
  output logic                        VALIDO,
  output logic                        FIM_CICLO
`ifdef MUX_VARREDURA_PARIDADE_EN
  , output logic                      PARIDADE
`endif
);

  localparam int          CW     = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;
  localparam int unsigned NC     = CANAIS;
  localparam logic [CW-1:0] ULTIMO = CW'(PERMANENCIA - 1);

  typedef enum logic [1:0] {PARADO, MANUAL, VARRENDO} estado_t;

  estado_t             estado, estado_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [SELW-1:0]     canal_d, prox;
  logic [LARGURA-1:0]  saida_d;
  logic                valido_d, fim_d;
  logic                sel_ok;
  logic [LARGURA-1:0]  ch [CANAIS];

  always_comb begin
    for (int unsigned i = 0; i < NC; i++) ch[i] = ENTRADAS[i*LARGURA +: LARGURA];
  end

  assign sel_ok = (32'(SEL) < NC);

  // First enabled channel strictly after CANAL, wrapping; lands on CANAL itself if it is the only one.
  always_comb begin
    int unsigned idx;
    logic        achou;
    prox  = CANAL;
    achou = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NC; k++) begin
      idx = (32'(CANAL) + k) % NC;
      if (!achou && MASCARA[idx[SELW-1:0]]) begin
        prox  = idx[SELW-1:0];
        achou = 1'b1;
      end
    end
  end

  always_comb begin
    estado_d = estado;
    cnt_d    = cnt;
    canal_d  = CANAL;
    saida_d  = SAIDA;
    valido_d = 1'b0;
    fim_d    = 1'b0;
    if (!HABILITA) begin
      estado_d = PARADO;
      cnt_d    = '0;
    end else begin
      case (estado)
        PARADO: begin
          estado_d = MODO ? VARRENDO : MANUAL;
          cnt_d    = '0;
        end
        MANUAL: begin
          if (MODO) begin
            estado_d = VARRENDO;
            cnt_d    = '0;
            saida_d  = ch[CANAL];
            valido_d = MASCARA[CANAL];
          end else if (sel_ok) begin
            saida_d  = ch[SEL];
            canal_d  = SEL;
            valido_d = MASCARA[SEL];
          end else begin
            saida_d  = '0;
          end
        end
        VARRENDO: begin
          if (!MODO) begin
            estado_d = MANUAL;
            cnt_d    = '0;
            saida_d  = ch[CANAL];
            valido_d = MASCARA[CANAL];
          end else begin
            if (MASCARA == '0) begin
              cnt_d = '0;
            end else if (!MASCARA[CANAL] || cnt == ULTIMO) begin
              cnt_d   = '0;
              canal_d = prox;
              fim_d   = (prox <= CANAL);
            end else begin
              cnt_d = cnt + 1'b1;
            end
            // Load the channel that CANAL will show, so SAIDA and CANAL stay coherent.
            saida_d  = ch[canal_d];
            valido_d = MASCARA[canal_d];
          end
        end
        default: estado_d = PARADO;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado    <= PARADO;
      cnt       <= '0;
      SAIDA     <= '0;
      CANAL     <= '0;
      VALIDO    <= 1'b0;
      FIM_CICLO <= 1'b0;
    end else begin
      estado    <= estado_d;
      cnt       <= cnt_d;
      SAIDA     <= saida_d;
      CANAL     <= canal_d;
      VALIDO    <= valido_d;
      FIM_CICLO <= fim_d;
    end
  end

`ifdef MUX_VARREDURA_PARIDADE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) PARIDADE <= 1'b0;
    else        PARIDADE <= valido_d & (^saida_d);
  end
`endif

endmodule

// File: tb/tb_mux_varredura.sv
// Randomized self-checking bench for mux_varredura against a cycle-level behavioural model.
module tb_mux_varredura;

  localparam int CANAIS = 8;
  localparam int LARGURA = 4;
  localparam int PERM = 4;
  localparam int SELW = (CANAIS > 2) ? $clog2(CANAIS) : 1;

  logic                      CLK = 1'b0;
  logic                      RST_N;
  logic [CANAIS*LARGURA-1:0] ENTRADAS;
  logic [CANAIS-1:0]         MASCARA;
  logic                      HABILITA;
  logic                      MODO;
  logic [SELW-1:0]           SEL;
  logic [LARGURA-1:0]        SAIDA;
  logic [SELW-1:0]           CANAL;
  logic                      VALIDO;
  logic                      FIM_CICLO;
`ifdef MUX_VARREDURA_PARIDADE_EN
  logic                      PARIDADE;
`endif

  mux_varredura #(.CANAIS(CANAIS), .LARGURA(LARGURA), .PERMANENCIA(PERM)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENTRADAS(ENTRADAS), .MASCARA(MASCARA),
    .HABILITA(HABILITA), .MODO(MODO), .SEL(SEL), .SAIDA(SAIDA), .CANAL(CANAL),
    .VALIDO(VALIDO), .FIM_CICLO(FIM_CICLO)
`ifdef MUX_VARREDURA_PARIDADE_EN
    , .PARIDADE(PARIDADE)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err = 0;

  typedef enum {M_PARADO, M_MANUAL, M_VARRENDO} m_estado_t;
  m_estado_t   m_st;
  int unsigned m_cnt, m_canal, m_saida;
  bit          m_val, m_fim;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned chan(input int unsigned i);
    return (ENTRADAS >> (i * LARGURA)) & ((1 << LARGURA) - 1);
  endfunction

  task automatic model_reset();
    m_st = M_PARADO; m_cnt = 0; m_canal = 0; m_saida = 0; m_val = 0; m_fim = 0;
  endtask

  task automatic model_edge();
    int unsigned n;
    if (!RST_N) begin model_reset(); return; end
    m_fim = 0;
    if (!HABILITA) begin
      m_st = M_PARADO; m_cnt = 0; m_val = 0;
    end else if (m_st == M_PARADO) begin
      m_st = MODO ? M_VARRENDO : M_MANUAL; m_cnt = 0; m_val = 0;
    end else if (MODO != (m_st == M_VARRENDO)) begin
      m_st = MODO ? M_VARRENDO : M_MANUAL; m_cnt = 0;
      m_saida = chan(m_canal); m_val = MASCARA[m_canal];
    end else if (m_st == M_MANUAL) begin
      if (SEL < CANAIS) begin
        m_saida = chan(SEL); m_canal = SEL; m_val = MASCARA[SEL];
      end else begin
        m_saida = 0; m_val = 0;
      end
    end else begin
      if (MASCARA == 0) m_cnt = 0;
      else if (!MASCARA[m_canal] || m_cnt == PERM - 1) begin
        n = m_canal;
        do n = (n + 1) % CANAIS; while (!MASCARA[n]);
        m_fim = (n <= m_canal);
        m_canal = n;
        m_cnt = 0;
      end else m_cnt++;
      m_saida = chan(m_canal); m_val = MASCARA[m_canal];
    end
  endtask

  task automatic check_outputs();
    check("saida", 32'(SAIDA), m_saida);
    check("canal", 32'(CANAL), m_canal);
    check("valido", 32'(VALIDO), 32'(m_val));
    check("fim_ciclo", 32'(FIM_CICLO), 32'(m_fim));
`ifdef MUX_VARREDURA_PARIDADE_EN
    check("paridade", 32'(PARIDADE), m_val ? ($countones(m_saida) % 2) : 0);
`endif
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Called 1ns after an edge; asserts reset between edges and checks it acts without a clock.
  task automatic async_reset();
    RST_N = 1'b0;
    #2;
    model_reset();
    check_outputs();
    RST_N = 1'b1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < CANAIS; i++) ENTRADAS[i*LARGURA +: LARGURA] = LARGURA'($urandom);
  endtask

  initial begin
    int q[$];
    int fims, w, held;
    RST_N = 1'b0; HABILITA = 1'b0; MODO = 1'b0; SEL = '0; MASCARA = '0; ENTRADAS = '0;
    model_reset();

    // Reset held with random inputs
    repeat (3) begin
      rand_data(); MASCARA = CANAIS'($urandom); HABILITA = 1'b1; MODO = 1'($urandom); SEL = SELW'($urandom);
      step();
    end
    check("reset_saida", 32'(SAIDA), 0);
    RST_N = 1'b1; HABILITA = 1'b0;
    step();

    // Manual mode, channel i carries i+3
    for (int i = 0; i < CANAIS; i++) ENTRADAS[i*LARGURA +: LARGURA] = LARGURA'(i + 3);
    MASCARA = 8'hFF; HABILITA = 1'b1; MODO = 1'b0; SEL = 3'd5;
    step(); step();
    check("man_saida", 32'(SAIDA), 8);
    check("man_canal", 32'(CANAL), 5);
    check("man_valido", 32'(VALIDO), 1);
    MASCARA = 8'hDF;
    step();
    check("man_mascarado", 32'(VALIDO), 0);

    // Scan 0,2,5,7,0 with one wrap pulse
    async_reset();
    rand_data(); MODO = 1'b1; MASCARA = 8'b1010_0101; HABILITA = 1'b1;
    q.push_back(int'(CANAL)); fims = 0;
    repeat (18) begin
      step();
      if (int'(CANAL) != q[$]) q.push_back(int'(CANAL));
      if (FIM_CICLO) fims++;
    end
    check("scan_len", q.size(), 5);
    if (q.size() == 5) begin
      check("scan_seq1", q[1], 2);
      check("scan_seq2", q[2], 5);
      check("scan_seq3", q[3], 7);
      check("scan_seq4", q[4], 0);
    end
    check("scan_fim_count", fims, 1);

    // Reset mid-scan
    repeat (3) step();
    async_reset();
    check("reset_meio_canal", 32'(CANAL), 0);

    // All channels masked
    MASCARA = '0; fims = 0;
    repeat (8) begin step(); if (FIM_CICLO) fims++; end
    check("mask0_fim", fims, 0);
    check("mask0_canal", 32'(CANAL), 0);

    // Single enabled channel
    MASCARA = 8'h08;
    step();
    fims = 0;
    repeat (16) begin step(); if (FIM_CICLO) fims++; end
    check("unico_canal", 32'(CANAL), 3);
    check("unico_fim_count", fims, 4);

    // Clear current channel mid-dwell
    MASCARA = 8'hFF;
    step(); step();
    MASCARA = 8'hF7;
    step();
    check("mascara_meio", 32'(CANAL), 4);

    // HABILITA priority and resumed dwell
    MASCARA = 8'b1010_0101; w = 0;
    while (CANAL != 2 && w < 40) begin step(); w++; end
    check("busca_canal2", 32'(CANAL), 2);
    HABILITA = 1'b0; MODO = 1'b0;
    step();
    check("pausa_valido", 32'(VALIDO), 0);
    check("pausa_canal", 32'(CANAL), 2);
    MODO = 1'b1;
    step();
    HABILITA = 1'b1; held = 0; w = 0;
    step();
    while (CANAL == 2 && w < 20) begin held++; step(); w++; end
    check("dwell_retomada", held, 4);

`ifdef MUX_VARREDURA_PARIDADE_EN
    MODO = 1'b0; MASCARA = 8'hF7;
    ENTRADAS[1*LARGURA +: LARGURA] = 4'b0111;
    ENTRADAS[2*LARGURA +: LARGURA] = 4'b0110;
    ENTRADAS[3*LARGURA +: LARGURA] = 4'b0111;
    SEL = 3'd1; step(); step();
    check("par_impar", 32'(PARIDADE), 1);
    SEL = 3'd2; step();
    check("par_par", 32'(PARIDADE), 0);
    SEL = 3'd3; step();
    check("par_mascarado", 32'(PARIDADE), 0);
`endif

    // Randomized run
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      rand_data();
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: MASCARA = '0;
          1: MASCARA = CANAIS'(1) << $urandom_range(0, CANAIS - 1);
          default: MASCARA = CANAIS'($urandom);
        endcase
      end
      HABILITA = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 15) == 0) MODO = ~MODO;
      SEL = SELW'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
